// File: rtl/tinyqv_uart_pkg.sv
// Shared UART definitions for the tinyQV receive and transmit peripherals.
package tinyqv_uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_DIV   = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous ui_in pins; RESET_VAL sets the idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/tinyqv_uart_rx.sv
// 8N1 UART receiver for tinyQV: start-bit glitch rejection, single holding register,
// sticky framing/overrun flags cleared by a CPU read strobe.
module tinyqv_uart_rx
  import tinyqv_uart_pkg::*;
#(
  parameter int DIV_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rxd,
  input  logic [DIV_WIDTH-1:0] divider,
  input  logic                 data_read,
  output logic [7:0]           data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(UART_MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
  localparam logic [2:0]           LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t r_state;
  uart_rx_state_t w_nextState;

  logic                      w_rxs;
  logic                      r_rxsPrev;
  logic                      w_fall;
  logic [DIV_WIDTH-1:0]      w_divClamped;
  logic [DIV_WIDTH-1:0]      r_divQ;
  logic [DIV_WIDTH-1:0]      r_cnt;
  logic                      r_tick;
  logic                      r_bit;
  logic [2:0]                r_bitIdx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      w_byteDone;
  logic                      w_frameErr;

  sync_2ff #(.RESET_VAL(1'b1)) u_rxdSync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (uart_rxd),
    .o_q   (w_rxs)
  );

  assign w_fall       = r_rxsPrev & ~w_rxs;
  assign w_divClamped = (divider < MIN_DIV) ? MIN_DIV : divider;

  // Bit-period counter; a zero count registers the line into r_bit and raises r_tick for the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxsPrev <= 1'b1;
      r_divQ    <= MIN_DIV;
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_bit     <= 1'b1;
    end else begin
      r_rxsPrev <= w_rxs;
      r_bit     <= w_rxs;
      r_tick    <= (r_state != IDLE) && (r_cnt == '0);
      if (r_state == IDLE) begin
        if (w_fall) begin
          r_divQ <= w_divClamped;
          r_cnt  <= (w_divClamped >> 1) - ONE;
        end
      end else if (r_cnt == '0) begin
        r_cnt <= r_divQ - ONE;
      end else begin
        r_cnt <= r_cnt - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_nextState = START;
      START:   if (r_tick) w_nextState = r_bit ? IDLE : DATA;
      DATA:    if (r_tick && (r_bitIdx == LAST_BIT)) w_nextState = STOP;
      STOP:    if (r_tick) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_byteDone = (r_state == STOP) && r_tick && r_bit;
    w_frameErr = (r_state == STOP) && r_tick && !r_bit;
    rx_busy    = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitIdx <= '0;
      r_shift  <= '0;
    end else if ((r_state == START) && r_tick) begin
      r_bitIdx <= '0;
    end else if ((r_state == DATA) && r_tick) begin
      r_shift  <= {r_bit, r_shift[UART_DATA_BITS-1:1]};
      r_bitIdx <= r_bitIdx + 3'd1;
    end
  end

  // A read and a completing byte in the same cycle: the byte wins and no overrun is flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (data_read) begin
        data_valid    <= 1'b0;
        framing_error <= 1'b0;
        overrun       <= 1'b0;
      end
      if (w_byteDone) begin
        data_out   <= r_shift;
        data_valid <= 1'b1;
        if (data_valid && !data_read) overrun <= 1'b1;
      end
      if (w_frameErr) framing_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tinyqv_uart_rx.sv
// Self-checking bench for tinyqv_uart_rx: directed scenarios plus randomized frames
// compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_tinyqv_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rxd;
  logic [12:0] divider;
  logic        data_read;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        framing_error;
  logic        overrun;
  logic        rx_busy;

  int   tests = 0;
  int   fails = 0;
  int   edgeNum = 0;
  int   riseEdge = -1;
  bit   prevValid = 1'b0;
  int   frameStart = 0;

  logic [7:0] expData;
  bit         expValid;
  bit         expFe;
  bit         expOvr;

  tinyqv_uart_rx #(.DIV_WIDTH(13)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rxd      (uart_rxd),
    .divider       (divider),
    .data_read     (data_read),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .overrun       (overrun),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeNum <= edgeNum + 1;

  // Records the edge after which data_valid was first seen high.
  always @(negedge clk) begin
    if (data_valid && !prevValid) riseEdge = edgeNum;
    prevValid = data_valid;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called just after a negedge: 4 idle-high clocks, start bit, 8 data bits LSB first, stop bit.
  task automatic applyStimulus(input logic [7:0] b, input int d, input bit stopHigh);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b0;
    frameStart = edgeNum + 1;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (d) @(negedge clk);
    end
    uart_rxd = stopHigh;
    repeat (d) @(negedge clk);
  endtask

  task automatic pulseRead();
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic modelReset();
    expData  = 8'h00;
    expValid = 1'b0;
    expFe    = 1'b0;
    expOvr   = 1'b0;
  endtask

  task automatic modelRead();
    expValid = 1'b0;
    expFe    = 1'b0;
    expOvr   = 1'b0;
  endtask

  task automatic modelFrame(input logic [7:0] b, input bit stopHigh, input bit readAtStop);
    bit hadUnread;
    hadUnread = expValid && !readAtStop;
    if (readAtStop) modelRead();
    if (stopHigh) begin
      if (hadUnread) expOvr = 1'b1;
      expData  = b;
      expValid = 1'b1;
    end else begin
      expFe = 1'b1;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_data"},  {24'h0, data_out},      {24'h0, expData});
    checkOutput({tag, "_valid"}, {31'h0, data_valid},    {31'h0, expValid});
    checkOutput({tag, "_ferr"},  {31'h0, framing_error}, {31'h0, expFe});
    checkOutput({tag, "_ovr"},   {31'h0, overrun},       {31'h0, expOvr});
    checkOutput({tag, "_busy"},  {31'h0, rx_busy},       32'h0);
  endtask

  function automatic int validLatency(input int d);
    return 2 + d / 2 + 9 * d + 1;
  endfunction

  initial begin
    int gs;
    int tgt;
    bit anyBusy;
    int d;
    logic [7:0] b;
    bit stopHigh;
    bit wasValid;

    rst_n     = 1'b0;
    uart_rxd  = 1'b1;
    divider   = 13'd16;
    data_read = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkAll("reset");

    // Clean byte at 16 clocks/bit, including exact data_valid timing.
    applyStimulus(8'h55, 16, 1'b1);
    settle();
    modelFrame(8'h55, 1'b1, 1'b0);
    checkAll("clean");
    checkOutput("clean_riseEdge", riseEdge - frameStart, 32'd155);

    // Start-bit glitch of 5 clocks.
    pulseRead();
    modelRead();
    repeat (4) @(negedge clk);
    uart_rxd = 1'b0;
    gs = edgeNum + 1;
    repeat (5) @(negedge clk);
    uart_rxd = 1'b1;
    checkOutput("glitch_busyDuring", {31'h0, rx_busy}, 32'h1);
    while (edgeNum < gs + 11) @(negedge clk);
    checkOutput("glitch_busyAfter11", {31'h0, rx_busy}, 32'h0);
    checkOutput("glitch_valid", {31'h0, data_valid}, 32'h0);
    applyStimulus(8'hA5, 16, 1'b1);
    settle();
    modelFrame(8'hA5, 1'b1, 1'b0);
    checkAll("afterGlitch");

    // Framing error, held-low break, then recovery.
    divider = 13'd8;
    pulseRead();
    modelRead();
    applyStimulus(8'hA3, 8, 1'b0);
    settle();
    modelFrame(8'hA3, 1'b0, 1'b0);
    checkAll("framing");
    anyBusy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rx_busy) anyBusy = 1'b1;
    end
    checkOutput("break_noStart", {31'h0, anyBusy}, 32'h0);
    applyStimulus(8'h3C, 8, 1'b1);
    settle();
    modelFrame(8'h3C, 1'b1, 1'b0);
    checkAll("afterBreak");

    // Overrun: two bytes without a read.
    pulseRead();
    modelRead();
    applyStimulus(8'h12, 8, 1'b1);
    settle();
    modelFrame(8'h12, 1'b1, 1'b0);
    applyStimulus(8'h34, 8, 1'b1);
    settle();
    modelFrame(8'h34, 1'b1, 1'b0);
    checkAll("overrun");
    pulseRead();
    modelRead();
    checkAll("overrunRead");

    // Read strobe coinciding with completion of a second byte.
    applyStimulus(8'h5A, 8, 1'b1);
    settle();
    modelFrame(8'h5A, 1'b1, 1'b0);
    tgt = edgeNum + 5 + 2 + 8 / 2 + 9 * 8;
    fork
      applyStimulus(8'h7E, 8, 1'b1);
      begin
        while (edgeNum < tgt) @(negedge clk);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
      end
    join
    settle();
    modelFrame(8'h7E, 1'b1, 1'b1);
    checkAll("collision");

    // Asynchronous reset during data bit 3 of 0xFF.
    tgt = edgeNum + 5 + 4 * 8 + 4;
    fork
      applyStimulus(8'hFF, 8, 1'b1);
      begin
        while (edgeNum < tgt) @(negedge clk);
        checkOutput("midFrame_busy", {31'h0, rx_busy}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    settle();
    modelReset();
    checkAll("midReset");

    // Divider below the minimum is clamped to 4.
    divider = 13'd2;
    applyStimulus(8'hC9, 4, 1'b1);
    settle();
    modelFrame(8'hC9, 1'b1, 1'b0);
    checkAll("clamp");
    checkOutput("clamp_riseEdge", riseEdge - frameStart, validLatency(4));

    // Randomized frames.
    for (int n = 0; n < 12; n++) begin
      d        = $urandom_range(4, 20);
      b        = 8'($urandom_range(0, 255));
      stopHigh = ($urandom_range(0, 3) != 0);
      divider  = 13'(d);
      if ($urandom_range(0, 1) == 1) begin
        pulseRead();
        modelRead();
      end
      wasValid = expValid;
      applyStimulus(b, d, stopHigh);
      settle();
      modelFrame(b, stopHigh, 1'b0);
      checkAll($sformatf("rand%0d", n));
      if (stopHigh && !wasValid)
        checkOutput($sformatf("rand%0d_riseEdge", n), riseEdge - frameStart, validLatency(d));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
